// File: rtl/byte_serial_add_seq.sv
// ---------------------------------------------------------------------------
// byte_serial_add_seq
//
// Purpose:
//   Wide adder front end. It accepts one NBYTES-byte operand pair and walks
//   it LSB-first through a single shared 8-bit adder slice, one byte per
//   clock. The carry is chained between bytes in a register. The finished
//   sum, carry-out and signed-overflow flag are then presented on an output
//   handshake.
//
//   The 8-bit slice is a hybrid design. The low nibble uses carry-lookahead
//   and the high nibble uses a Kogge-Stone prefix tree. The slice also
//   exposes the carry into its bit 7, which the top level uses to form the
//   signed-overflow flag on the final byte.
//
// Configuration:
//   ADDSEQ_SUB_EN - when defined, adds the in_sub port. When in_sub is
//                   captured as 1 at accept, the block computes A-B: B bytes
//                   are inverted and the carry starts at 1. out_cout is then
//                   the not-borrow flag (1 when A >= B unsigned). When the
//                   macro is undefined the block only adds.
//
// Parameters:
//   NBYTES    operand width in bytes (2..16); W = 8*NBYTES
//
// Ports:
//   clk        in   1  system clock, all state on rising edge
//   rst        in   1  synchronous, active-high reset (highest priority)
//   in_valid   in   1  operand pair offered
//   in_ready   out  1  block can accept operands (IDLE and not in reset)
//   in_a       in   W  operand A
//   in_b       in   W  operand B
//   in_sub     in   1  subtract select (only with ADDSEQ_SUB_EN)
//   out_valid  out  1  result available (DONE and not in reset)
//   out_ready  in   1  consumer accepts result
//   out_sum    out  W  sum mod 2^W (registered)
//   out_cout   out  1  carry out of bit W-1 (registered)
//   out_ovf    out  1  signed overflow (registered)
//   busy       out  1  high in RUN or DONE (not in reset)
//   dbg_state  out  2  FSM state: 0=IDLE, 1=RUN, 2=DONE
//
// Handshake semantics (both ports):
//   A transfer happens on a rising edge where valid && ready are both high.
//   in_ready and out_valid depend only on the FSM state and rst; they never
//   depend on in_valid or out_ready. A producer may change its payload
//   freely once the transfer edge has passed. While out_valid is high the
//   result payload is held stable until the transfer edge.
// ---------------------------------------------------------------------------

module byte_serial_add_slice (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_c7,
  output logic       o_cout
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  // Kogge-Stone prefix terms for the high nibble (local bit index 0..3).
  logic [3:0] w_g1, w_p1;
  logic [3:0] w_g2, w_p2;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Low nibble: carry-lookahead, every carry written out flat from i_cin.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  // High nibble, level 1: span of 2 bits.
  assign w_g1[0] = w_g[4];
  assign w_p1[0] = w_p[4];
  assign w_g1[1] = w_g[5] | (w_p[5] & w_g[4]);
  assign w_p1[1] = w_p[5] & w_p[4];
  assign w_g1[2] = w_g[6] | (w_p[6] & w_g[5]);
  assign w_p1[2] = w_p[6] & w_p[5];
  assign w_g1[3] = w_g[7] | (w_p[7] & w_g[6]);
  assign w_p1[3] = w_p[7] & w_p[6];

  // High nibble, level 2: span of 4 bits. Each entry now covers bits 4..4+i.
  assign w_g2[0] = w_g1[0];
  assign w_p2[0] = w_p1[0];
  assign w_g2[1] = w_g1[1];
  assign w_p2[1] = w_p1[1];
  assign w_g2[2] = w_g1[2] | (w_p1[2] & w_g1[0]);
  assign w_p2[2] = w_p1[2] & w_p1[0];
  assign w_g2[3] = w_g1[3] | (w_p1[3] & w_g1[1]);
  assign w_p2[3] = w_p1[3] & w_p1[1];

  // Fold the nibble carry from the lookahead half into the prefix groups.
  assign w_c[5] = w_g2[0] | (w_p2[0] & w_c[4]);
  assign w_c[6] = w_g2[1] | (w_p2[1] & w_c[4]);
  assign w_c[7] = w_g2[2] | (w_p2[2] & w_c[4]);
  assign w_c[8] = w_g2[3] | (w_p2[3] & w_c[4]);

  assign o_sum  = w_p ^ w_c[7:0];
  assign o_c7   = w_c[7];
  assign o_cout = w_c[8];

endmodule

module byte_serial_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
`ifdef ADDSEQ_SUB_EN
  input  logic                in_sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  logic              r_ovf;
`ifdef ADDSEQ_SUB_EN
  logic              r_sub;
`endif

  logic [7:0]        w_a_byte;
  logic [7:0]        w_b_byte;
  logic [7:0]        w_slice_sum;
  logic              w_slice_c7;
  logic              w_slice_cout;
  logic              w_last;
  logic              w_accept;
  logic              w_init_carry;

  // ---------------------------------------------------------------------
  // Byte selection feeding the shared slice
  // ---------------------------------------------------------------------
  assign w_a_byte = r_a[8*r_idx +: 8];
`ifdef ADDSEQ_SUB_EN
  // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
  assign w_b_byte     = r_b[8*r_idx +: 8] ^ {8{r_sub}};
  assign w_init_carry = in_sub;
`else
  assign w_b_byte     = r_b[8*r_idx +: 8];
  assign w_init_carry = 1'b0;
`endif

  byte_serial_add_slice u_slice (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_c7   (w_slice_c7),
    .o_cout (w_slice_cout)
  );

  assign w_last   = (r_idx == IDXW'(NBYTES - 1));
  assign w_accept = in_valid && (r_state == S_IDLE);

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, index, carry and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_idx   <= '0;
        r_carry <= w_init_carry;
`ifdef ADDSEQ_SUB_EN
        r_sub   <= in_sub;
`endif
      end
      if (r_state == S_RUN) begin
        r_sum[8*r_idx +: 8] <= w_slice_sum;
        r_carry             <= w_slice_cout;
        if (w_last) begin
          // Overflow uses the carry into the MSB of the whole word, which
          // is bit 7 of the final byte.
          r_cout <= w_slice_cout;
          r_ovf  <= w_slice_c7 ^ w_slice_cout;
          // Park the index at 0 rather than wrapping past NBYTES-1.
          r_idx  <= '0;
        end else begin
          r_idx  <= r_idx + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: handshake flags decode from state, gated off during reset
  // ---------------------------------------------------------------------
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE) && !rst;
  assign busy      = ((r_state == S_RUN) || (r_state == S_DONE)) && !rst;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign dbg_state = r_state;

endmodule
